// File: rtl/turn_banner_writer.sv
// Copies the side-to-play bitmap (or zeros) into the banner RAM,
// starting on the rising edge of vertical blank.
module turn_banner_writer #(
  parameter int BANNER_W = 80,
  parameter int BANNER_H = 45,
  parameter int DEPTH    = BANNER_W * BANNER_H,
  parameter int ADDR_W   = 12,
  parameter int PIX_W    = 2,
  parameter int VBLANK_Y = 480
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawY,
  input  logic              req,
  input  logic              req_turn,
  input  logic              req_clear,
  output logic              busy,
  output logic              done,
  output logic              src_sel,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBL,
    COPY,
    DRAIN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [9:0]        VBL_Y = 10'(VBLANK_Y);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              clr_q, clr_d;
  logic              pend_q, pend_d;
  logic              psel_q, psel_d;
  logic              pclr_q, pclr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vbl_q;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              vblank;
  logic              vblank_rise;

  assign vblank      = (DrawY >= VBL_Y);
  assign vblank_rise = vblank & ~vbl_q;

  assign src_rd_en = (state_q == COPY);
  assign src_addr  = src_rd_en ? cnt_q : '0;
  assign src_sel   = sel_q;
  // a request landing on the done cycle keeps busy continuous
  assign busy      = busy_q | (done_q & req);
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    clr_d   = clr_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    pclr_d  = pclr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (req && state_q != IDLE) begin
      pend_d = 1'b1;
      psel_d = req_turn;
      pclr_d = req_clear;
    end
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT_VBL;
          sel_d   = req_turn;
          clr_d   = req_clear;
          busy_d  = 1'b1;
        end
      end
      WAIT_VBL: begin
        if (vblank_rise) begin
          state_d = COPY;
          cnt_d   = '0;
        end
      end
      COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (done_q) begin
          if (pend_d) begin
            state_d = WAIT_VBL;
            sel_d   = psel_d;
            clr_d   = pclr_d;
            pend_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else if (!v1_q && wr_en_q) begin
          done_d = 1'b1;
          busy_d = pend_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    v1_d      = src_rd_en;
    a1_d      = src_addr;
    wr_en_d   = v1_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (v1_q) begin
      wr_addr_d = a1_q;
      wr_data_d = clr_q ? '0 : src_data;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      clr_q     <= 1'b0;
      pend_q    <= 1'b0;
      psel_q    <= 1'b0;
      pclr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vbl_q     <= 1'b0;
      v1_q      <= 1'b0;
      a1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      clr_q     <= clr_d;
      pend_q    <= pend_d;
      psel_q    <= psel_d;
      pclr_q    <= pclr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vbl_q     <= vblank;
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_turn_banner_writer.sv
// Directed bench for turn_banner_writer with a registered source ROM model.
module tb_turn_banner_writer;

  localparam int DEPTH = 3600;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawY = 10'd100;
  logic        req = 1'b0;
  logic        req_turn = 1'b0;
  logic        req_clear = 1'b0;
  logic        busy, done, src_sel, src_rd_en;
  logic [11:0] src_addr;
  logic [1:0]  src_data = 2'd0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [1:0]  wr_data;

  int checks = 0;
  int errors = 0;

  turn_banner_writer dut (
    .vga_clk   (clk),
    .reset_n   (reset_n),
    .DrawY     (DrawY),
    .req       (req),
    .req_turn  (req_turn),
    .req_clear (req_clear),
    .busy      (busy),
    .done      (done),
    .src_sel   (src_sel),
    .src_rd_en (src_rd_en),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] rom(input logic s, input logic [11:0] a);
    return s ? ~(a[2:1] ^ a[6:5]) : (a[1:0] ^ a[4:3]);
  endfunction

  always @(posedge clk)
    if (src_rd_en) src_data <= rom(src_sel, src_addr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic t, input logic c);
    req       = 1'b1;
    req_turn  = t;
    req_clear = c;
    tick();
    req = 1'b0;
    chk("busy after req", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_quiet(input string tag, input int n, input logic eb);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wr_en || done || busy !== eb) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic run_update(input string tag, input logic sel,
                            input logic clr, input int rst_at,
                            input int req_a, input logic turn_a,
                            input int req_b, input logic turn_b,
                            input bit req_done, input logic turn_d,
                            input logic exp_busy_end);
    int nwr = 0;
    int bad = 0;
    int first_k = -1;
    int done_k = -1;
    int ndone = 0;
    logic busy_end = 1'b0;
    logic [1:0] exp;
    DrawY = 10'd479;
    tick();
    DrawY = 10'd480;
    for (int k = 1; k <= DEPTH + 10 && done_k < 0; k++) begin
      tick();
      req = 1'b0;
      if (src_rd_en && src_addr !== 12'(k - 1)) bad++;
      if (src_sel !== sel) bad++;
      if (wr_en) begin
        exp = clr ? 2'd0 : rom(sel, 12'(nwr));
        if (first_k < 0) first_k = k;
        if (wr_addr !== 12'(nwr) || wr_data !== exp) bad++;
        if (nwr == rst_at) begin
          reset_n = 1'b0;
          #1;
          chk({tag, " reset outs"},
              {1'b0, busy, done, src_sel, src_rd_en, src_addr,
               wr_en, wr_addr, wr_data}, 32'd0);
          chk({tag, " bad before reset"}, bad, 0);
          return;
        end
        if (nwr == req_a || nwr == req_b) begin
          req       = 1'b1;
          req_turn  = (nwr == req_a) ? turn_a : turn_b;
          req_clear = 1'b0;
        end
        nwr++;
      end
      if (done) begin
        ndone++;
        done_k = k;
        if (req_done) begin
          req       = 1'b1;
          req_turn  = turn_d;
          req_clear = 1'b0;
          #1;
        end
        busy_end = busy;
      end else if (busy !== 1'b1) begin
        bad++;
      end
    end
    tick();
    req = 1'b0;
    chk({tag, " extra done"}, {31'd0, done}, 32'd0);
    chk({tag, " writes"}, nwr, DEPTH);
    chk({tag, " bad beats"}, bad, 0);
    chk({tag, " first write cycle"}, first_k, 3);
    chk({tag, " done cycle"}, done_k, DEPTH + 3);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " busy at done"}, {31'd0, busy_end}, {31'd0, exp_busy_end});
  endtask

  initial begin
    tick();
    tick();
    chk("reset outs",
        {1'b0, busy, done, src_sel, src_rd_en, src_addr,
         wr_en, wr_addr, wr_data}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle busy", {31'd0, busy}, 32'd0);

    // black copy requested mid-frame, then sweep to vblank
    do_req(1'b1, 1'b0);
    begin
      int early = 0;
      for (int y = 100; y < 480; y++) begin
        DrawY = 10'(y);
        tick();
        if (wr_en) early++;
      end
      chk("no write before vblank", early, 0);
    end
    run_update("black", 1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    DrawY = 10'd100;
    wait_quiet("idle after black", 5, 1'b0);

    // clear keeps the latched turn on src_sel
    do_req(1'b1, 1'b1);
    run_update("clear", 1'b1, 1'b1, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // request already inside vblank waits a frame
    DrawY = 10'd490;
    tick();
    tick();
    do_req(1'b0, 1'b0);
    wait_quiet("in-vblank req waits", 20, 1'b1);
    DrawY = 10'd100;
    wait_quiet("still waiting", 5, 1'b1);
    run_update("white late", 1'b0, 1'b0, -1, -1, 1'b0, -1, 1'b0, 1'b0,
               1'b0, 1'b0);

    // two requests during a copy, latest wins
    DrawY = 10'd100;
    tick();
    do_req(1'b0, 1'b0);
    run_update("white pend", 1'b0, 1'b0, -1, 100, 1'b0, 2000, 1'b1, 1'b0,
               1'b0, 1'b1);
    DrawY = 10'd100;
    wait_quiet("pending wait", 5, 1'b1);
    run_update("black pend", 1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b0, 1'b0,
               1'b0, 1'b0);

    // reset in the middle of an update
    DrawY = 10'd100;
    tick();
    do_req(1'b0, 1'b0);
    run_update("abort", 1'b0, 1'b0, 1000, -1, 1'b0, -1, 1'b0, 1'b0,
               1'b0, 1'b0);
    tick();
    chk("held reset wr_en", {31'd0, wr_en}, 32'd0);
    reset_n = 1'b1;
    DrawY = 10'd100;
    wait_quiet("after reset", 3, 1'b0);
    do_req(1'b1, 1'b0);
    run_update("fresh", 1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // request on the done cycle
    DrawY = 10'd100;
    tick();
    do_req(1'b0, 1'b1);
    run_update("clear done-req", 1'b0, 1'b1, -1, -1, 1'b0, -1, 1'b0, 1'b1,
               1'b1, 1'b1);
    DrawY = 10'd100;
    wait_quiet("done-req wait", 5, 1'b1);
    run_update("follow-up", 1'b1, 1'b0, -1, -1, 1'b0, -1, 1'b0, 1'b0,
               1'b0, 1'b0);
    DrawY = 10'd100;
    wait_quiet("final idle", 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_banner_writer.md
# turn_banner_writer

Sequential writer that fills the 80x45 "side to play" banner buffer, a 2-bit palette-indexed dual-port RAM. The HDMI piece controller's banner renderer reads that RAM at display time. On request, the block copies the white-to-play or black-to-play source bitmap into the buffer, or clears it to index 0. All writes happen during vertical blanking, so the renderer never displays a half-updated banner.

## Interface
Parameters:
- BANNER_W, 80, banner width in pixels
- BANNER_H, 45, banner height in pixels
- DEPTH, BANNER_W*BANNER_H (3600), number of words copied per update
- ADDR_W, 12, address width for source and destination
- PIX_W, 2, palette index width
- VBLANK_Y, 480, first DrawY value of vertical blank

Ports:
- vga_clk  in  1  sole clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawY  in  10  current scan line from the VGA controller
- req  in  1  one-cycle update request
- req_turn  in  1  side to display: 0 = white to play, 1 = black to play; sampled with req
- req_clear  in  1  when high with req, fill the buffer with index 0 instead of copying; sampled with req
- busy  out  1  high from request acceptance through the final write
- done  out  1  one-cycle pulse after the final write of an update
- src_sel  out  1  selects the source ROM (0 = white, 1 = black); stable while busy
- src_rd_en  out  1  source ROM read enable
- src_addr  out  ADDR_W  source ROM address
- src_data  in  PIX_W  source ROM output, registered and valid one cycle after src_addr
- wr_en  out  1  banner RAM write enable
- wr_addr  out  ADDR_W  banner RAM write address
- wr_data  out  PIX_W  banner RAM write data

## Operation
- vblank = (DrawY >= VBLANK_Y).
- vblank_q is vblank registered by one cycle.
- vblank_rise = vblank & ~vblank_q.
- States are IDLE, WAIT_VBL, COPY and DRAIN.
- IDLE -> WAIT_VBL on req.
  - Latch req_turn into src_sel and req_clear into clr_q.
  - Set busy.
- WAIT_VBL -> COPY on vblank_rise, with cnt = 0.
  - A request accepted while already inside vblank waits for the next frame's rising edge.
- COPY:
  - src_rd_en = 1 and src_addr = cnt, decoded combinationally from state and cnt.
  - cnt increments every cycle.
  - When cnt = DEPTH-1, move to DRAIN.
- Write stage:
  - A 2-stage valid/address pipeline delays each read.
  - wr_en / wr_addr / wr_data are registered outputs.
  - wr_data = clr_q ? 0 : src_data.
  - In clear mode the ROM is still addressed, so timing is identical in both modes.
- DRAIN:
  - Holds until the pipeline empties.
  - Then pulses done for one cycle, clears busy and returns to IDLE.
- Requests while busy:
  - Do not abort the current update.
  - Set a pending flag and overwrite the pending turn/clear with the latest values.
  - On the done cycle, if pending is set, go directly to WAIT_VBL with the pending values loaded and busy held high. busy does not drop in this case.
- req on the same cycle as done (pending clear) is treated as a pending request: same outcome.
- Addresses never exceed DEPTH-1. No wrap-around write is ever issued.

## Timing
- Reset (async, immediate) sets:
  - busy = 0, done = 0, src_sel = 0, src_rd_en = 0, src_addr = 0;
  - wr_en = 0, wr_addr = 0, wr_data = 0;
  - state = IDLE, pending = 0, cnt = 0.
- Reset mid-update abandons the buffer contents as partially written. wr_en drops with no further writes.
- busy rises the cycle after req.
- src_addr = a is driven in the a-th cycle after COPY entry.
- wr_addr = a, with wr_en = 1, appears exactly 2 cycles after src_addr = a.
- Writes are contiguous: DEPTH consecutive wr_en cycles, addresses 0..DEPTH-1 ascending.
- done pulses the cycle after the last write (wr_addr = DEPTH-1). busy falls in that same cycle unless a request is pending.
- Update length from vblank_rise is DEPTH+3 cycles (3603). This is well inside the 36000-cycle vblank at 800 clocks per line.
- One update per vblank at most.

## Test plan
- Reset, req with req_turn=1 and req_clear=0 at DrawY=100, then sweep DrawY -> no wr_en before DrawY reaches 480. Then 3600 contiguous writes with wr_addr 0..3599 and wr_data equal to the black ROM at src_addr-2. done pulses once and busy clears.
- req with req_clear=1 -> 3600 writes, all with wr_data=0. src_sel unchanged from the latched req_turn.
- req asserted at DrawY=490 (already in vblank) -> no writes until the next 479->480 transition.
- Two reqs during a copy (turn=0 then turn=1) -> the first update completes. busy stays high and the second update runs at the next vblank with src_sel=1. Exactly two done pulses.
- Deassert reset_n at write 1000 -> all outputs 0 immediately. After release, req produces a full fresh update starting at wr_addr 0.
- req on the same cycle as done -> busy never drops, and the follow-up update runs in the next frame.
